mealy_seq_detector: RTL and testbench

Parametrised Mealy serial-pattern detector that generalises the two-consecutive-ones Mealy FSM. It compares the serial input `w` against an N-bit pattern. The pattern is set by parameter at reset and can be reloaded at run time. Matching is selectable between overlapping and non-overlapping modes. The block keeps a saturating count of matches and sits alongside the existing state-machine examples as a reusable front-end for serial protocol framing.

---
 rtl/mealy_seq_detector_pkg.sv | 29 ++
 rtl/mealy_seq_detector_if.sv | 36 +++
 rtl/mealy_seq_detector_sat_counter.sv | 38 +++
 rtl/mealy_seq_detector.sv | 109 ++++++++++
 tb/tb_mealy_seq_detector.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/mealy_seq_detector_pkg.sv
// Shared constants and helpers for the serial pattern detector.
// Default pattern/width values and the sizing function for the fill counter.
package mealy_seq_detector_pkg;

  localparam int         DEF_N       = 2;
  localparam logic [1:0] DEF_PATTERN = 2'b11;
  localparam bit         DEF_OVERLAP = 1'b1;
  localparam int         DEF_CW      = 8;
  localparam int         MIN_N       = 2;
  localparam int         MAX_N       = 16;

  // What the history/pattern registers do on a given clock edge.
  typedef enum logic [1:0] {
    ACT_HOLD  = 2'd0,
    ACT_LOAD  = 2'd1,
    ACT_SHIFT = 2'd2
  } act_e;

  // Ceiling log2, never below one bit so the fill counter always exists.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mealy_seq_detector_if.sv
// Serial data, pattern-load and match-count signals of the pattern detector.
// The master side drives the stream; the slave side is the detector.
interface mealy_seq_detector_if #(
  parameter int N  = 2,
  parameter int CW = 8
);

  logic          En;
  logic          w;
  logic          PatLoad;
  logic [N-1:0]  PatIn;
  logic          CountClr;
  logic          z;
  logic [CW-1:0] MatchCount;

  modport master (
    output En,
    output w,
    output PatLoad,
    output PatIn,
    output CountClr,
    input  z,
    input  MatchCount
  );

  modport slave (
    input  En,
    input  w,
    input  PatLoad,
    input  PatIn,
    input  CountClr,
    output z,
    output MatchCount
  );

endinterface

// File: rtl/mealy_seq_detector_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment,
// and the count sticks at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_reg;
  logic [W-1:0] q_next;
  logic         at_max;

  assign at_max = (q_reg == {W{1'b1}});

  always_comb begin
    q_next = q_reg;
    if (clr) begin
      q_next = '0;
    end else if (inc && !at_max) begin
      q_next = q_reg + W'(1);
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_next;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/mealy_seq_detector.sv
// Mealy serial-pattern detector: N-bit reloadable pattern, overlapping or
// restart-after-match modes, zero-latency z and a saturating match counter.
module mealy_seq_detector
  import mealy_seq_detector_pkg::*;
#(
  parameter int           N       = DEF_N,
  parameter logic [N-1:0] PATTERN = N'(DEF_PATTERN),
  parameter bit           OVERLAP = DEF_OVERLAP,
  parameter int           CW      = DEF_CW
) (
  input logic                 Clock,
  input logic                 Resetn,
  mealy_seq_detector_if.slave bus
);

  localparam int            FW       = clog2(N);
  localparam logic [FW-1:0] FILL_MAX = FW'(N - 1);

  act_e          act;
  logic [FW-1:0] fill_reg;
  logic [FW-1:0] fill_next;
  logic [N-2:0]  hist_reg;
  logic [N-2:0]  hist_next;
  logic [N-2:0]  hist_shift;
  logic [N-1:0]  pat_reg;
  logic [N-1:0]  pat_next;
  logic [N-1:0]  cand;
  logic [N-1:0]  bit_eq;
  logic          armed;
  logic          z;

  // Candidate word: stored history followed by the bit on the wire now.
  assign cand = {hist_reg, bus.w};

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cmp
      assign bit_eq[gi] = ~(cand[gi] ^ pat_reg[gi]);
    end

    if (N == 2) begin : g_hist_n2
      assign hist_shift = bus.w;
    end else begin : g_hist_wide
      assign hist_shift = {hist_reg[N-3:0], bus.w};
    end
  endgenerate

  // A pattern load wins over sampling; the wire bit on a load edge is dropped.
  always_comb begin
    act = ACT_HOLD;
    if (bus.PatLoad) begin
      act = ACT_LOAD;
    end else if (bus.En) begin
      act = ACT_SHIFT;
    end
  end

  assign armed = (fill_reg == FILL_MAX);
  assign z     = (act == ACT_SHIFT) && armed && (&bit_eq);

  always_comb begin
    fill_next = fill_reg;
    hist_next = hist_reg;
    pat_next  = pat_reg;
    unique case (act)
      ACT_LOAD: begin
        pat_next  = bus.PatIn;
        fill_next = '0;
        hist_next = '0;
      end
      ACT_SHIFT: begin
        hist_next = hist_shift;
        if (z && !OVERLAP) begin
          fill_next = '0;
        end else if (!armed) begin
          fill_next = fill_reg + FW'(1);
        end
      end
      default: begin
        fill_next = fill_reg;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      fill_reg <= '0;
      hist_reg <= '0;
      pat_reg  <= PATTERN;
    end else begin
      fill_reg <= fill_next;
      hist_reg <= hist_next;
      pat_reg  <= pat_next;
    end
  end

  sat_counter #(
    .W (CW)
  ) u_match_cnt (
    .Clock  (Clock),
    .Resetn (Resetn),
    .clr    (bus.CountClr),
    .inc    (z),
    .q      (bus.MatchCount)
  );

  assign bus.z = z;

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Directed bench for mealy_seq_detector: four configurations driven on the
// falling edge, z checked mid-cycle and MatchCount checked after the edge.
module tb_mealy_seq_detector;

  logic clk;
  logic resetn;
  int   checks;
  int   failures;

  mealy_seq_detector_if #(.N(2), .CW(8)) ifa ();
  mealy_seq_detector_if #(.N(3), .CW(8)) ifb ();
  mealy_seq_detector_if #(.N(3), .CW(8)) ifc ();
  mealy_seq_detector_if #(.N(2), .CW(2)) ifd ();

  mealy_seq_detector dut_a (
    .Clock  (clk),
    .Resetn (resetn),
    .bus    (ifa)
  );

  mealy_seq_detector #(.N(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CW(8)) dut_b (
    .Clock  (clk),
    .Resetn (resetn),
    .bus    (ifb)
  );

  mealy_seq_detector #(.N(3), .PATTERN(3'b101), .OVERLAP(1'b0), .CW(8)) dut_c (
    .Clock  (clk),
    .Resetn (resetn),
    .bus    (ifc)
  );

  mealy_seq_detector #(.N(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CW(2)) dut_d (
    .Clock  (clk),
    .Resetn (resetn),
    .bus    (ifd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_all();
    ifa.En = 1'b0; ifa.PatLoad = 1'b0; ifa.CountClr = 1'b0;
    ifb.En = 1'b0; ifb.PatLoad = 1'b0; ifb.CountClr = 1'b0;
    ifc.En = 1'b0; ifc.PatLoad = 1'b0; ifc.CountClr = 1'b0;
    ifd.En = 1'b0; ifd.PatLoad = 1'b0; ifd.CountClr = 1'b0;
  endtask

  task automatic step_a(input logic en, input logic w, input logic pl,
                        input logic [1:0] pin, input logic expz, input string tag);
    @(negedge clk);
    ifa.En = en; ifa.w = w; ifa.PatLoad = pl; ifa.PatIn = pin;
    #1;
    chk(tag, 32'(ifa.z), 32'(expz));
    $display("a %s en=%0b w=%0b load=%0b z=%0b", tag, en, w, pl, ifa.z);
    @(posedge clk);
    #1;
    idle_all();
  endtask

  task automatic step_bc(input logic w, input logic expb, input logic expc, input string tag);
    @(negedge clk);
    ifb.En = 1'b1; ifb.w = w;
    ifc.En = 1'b1; ifc.w = w;
    #1;
    chk({tag, "_ov1"}, 32'(ifb.z), 32'(expb));
    chk({tag, "_ov0"}, 32'(ifc.z), 32'(expc));
    $display("bc %s w=%0b z_ov1=%0b z_ov0=%0b", tag, w, ifb.z, ifc.z);
    @(posedge clk);
    #1;
    idle_all();
  endtask

  task automatic step_d(input logic w, input logic clr, input logic expz, input string tag);
    @(negedge clk);
    ifd.En = 1'b1; ifd.w = w; ifd.CountClr = clr;
    #1;
    chk(tag, 32'(ifd.z), 32'(expz));
    $display("d %s w=%0b clr=%0b z=%0b", tag, w, clr, ifd.z);
    @(posedge clk);
    #1;
    idle_all();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    resetn   = 1'b0;
    idle_all();
    ifa.w = 1'b0; ifa.PatIn = '0;
    ifb.w = 1'b0; ifb.PatIn = '0;
    ifc.w = 1'b0; ifc.PatIn = '0;
    ifd.w = 1'b0; ifd.PatIn = '0;

    // Reset state
    #12;
    chk("rst_z_a", 32'(ifa.z), 32'd0);
    chk("rst_cnt_a", 32'(ifa.MatchCount), 32'd0);
    chk("rst_cnt_b", 32'(ifb.MatchCount), 32'd0);
    chk("rst_cnt_d", 32'(ifd.MatchCount), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Default pattern 11, overlapping
    step_a(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, "def_w0");
    step_a(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, "def_w1a");
    step_a(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, "def_w1b");
    step_a(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, "def_w1c");
    step_a(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, "def_w0b");
    step_a(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, "def_w1d");
    chk("def_cnt", 32'(ifa.MatchCount), 32'd2);

    // Enable gaps: clear history with a reload of 11 first
    step_a(1'b0, 1'b0, 1'b1, 2'b11, 1'b0, "gap_reload");
    step_a(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, "gap_first");
    step_a(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, "gap_idle1");
    step_a(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, "gap_idle2");
    step_a(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, "gap_idle3");
    step_a(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, "gap_last");
    chk("gap_cnt", 32'(ifa.MatchCount), 32'd3);

    // Run-time reload to pattern 01
    step_a(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, "rl_pre");
    step_a(1'b1, 1'b1, 1'b1, 2'b01, 1'b0, "rl_load");
    step_a(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, "rl_w0");
    step_a(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, "rl_w1");
    step_a(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, "rl_old11");
    chk("rl_cnt", 32'(ifa.MatchCount), 32'd5);

    // N=3 pattern 101, overlapping and non-overlapping side by side
    step_bc(1'b1, 1'b0, 1'b0, "p101_b1");
    step_bc(1'b0, 1'b0, 1'b0, "p101_b2");
    step_bc(1'b1, 1'b1, 1'b1, "p101_b3");
    step_bc(1'b0, 1'b0, 1'b0, "p101_b4");
    step_bc(1'b1, 1'b1, 1'b0, "p101_b5");
    chk("p101_cnt_ov1", 32'(ifb.MatchCount), 32'd2);
    chk("p101_cnt_ov0", 32'(ifc.MatchCount), 32'd1);

    // Async reset mid-sequence; restores pattern 11 and clears the count
    @(negedge clk);
    resetn = 1'b0;
    #1;
    resetn = 1'b1;
    chk("ar_cnt_clr", 32'(ifa.MatchCount), 32'd0);
    step_a(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, "ar_w1");
    @(negedge clk);
    #1;
    resetn = 1'b0;
    #2;
    chk("ar_z_in_rst", 32'(ifa.z), 32'd0);
    resetn = 1'b1;
    step_a(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, "ar_after");
    chk("ar_cnt", 32'(ifa.MatchCount), 32'd0);
    step_a(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, "ar_recover");
    chk("ar_cnt_rec", 32'(ifa.MatchCount), 32'd1);

    // Saturation at CW=2, then clear on a matching cycle
    step_d(1'b1, 1'b0, 1'b0, "sat_fill");
    step_d(1'b1, 1'b0, 1'b1, "sat_m1");
    step_d(1'b1, 1'b0, 1'b1, "sat_m2");
    step_d(1'b1, 1'b0, 1'b1, "sat_m3");
    chk("sat_cnt3", 32'(ifd.MatchCount), 32'd3);
    step_d(1'b1, 1'b0, 1'b1, "sat_m4");
    step_d(1'b1, 1'b0, 1'b1, "sat_m5");
    chk("sat_hold", 32'(ifd.MatchCount), 32'd3);
    step_d(1'b1, 1'b1, 1'b1, "sat_clr");
    chk("sat_cnt_clr", 32'(ifd.MatchCount), 32'd0);
    step_d(1'b1, 1'b0, 1'b1, "sat_after");
    chk("sat_cnt_after", 32'(ifd.MatchCount), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
